// File: rtl/reg_bank_pkg.sv
// Shared integer register-file types and defaults, used by decode, execute,
// writeback and the register bank itself.
package reg_bank_pkg;

  localparam int DEF_XLEN     = 32;
  localparam int DEF_NUM_REGS = 32;

  typedef logic [4:0]          r_t;
  typedef logic [DEF_XLEN-1:0] data_t;

  localparam r_t X0 = 5'd0;

endpackage

// File: rtl/reg_bypass.sv
// Selects the value seen by one read port: same-edge writeback data or the stored
// register. Forwarding exists only when REG_WB_BYPASS_EN is defined.
module reg_bypass
  import reg_bank_pkg::*;
#(
  parameter int W = DEF_XLEN
) (
  input  r_t           rs_addr_i,
  input  r_t           rd_addr_i,
  input  logic         rd_wren_i,
  input  logic [W-1:0] rd_data_i,
  input  logic [W-1:0] reg_val_i,
  output logic [W-1:0] value_o
);

`ifdef REG_WB_BYPASS_EN
  logic hit;
  assign hit     = rd_wren_i && (rd_addr_i == rs_addr_i) && (rs_addr_i != X0);
  assign value_o = hit ? rd_data_i : reg_val_i;
`else
  // Without forwarding the reader sees the pre-write value; hazard logic must stall.
  logic unused_wb;
  assign unused_wb = ^{rs_addr_i, rd_addr_i, rd_wren_i, rd_data_i};
  assign value_o   = reg_val_i;
`endif

endmodule

// File: rtl/reg_bank.sv
// Integer register file x0..x31: two registered read ports, one write port, x0 = 0.
// Optional same-edge writeback forwarding is enabled by defining REG_WB_BYPASS_EN.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  r_t              rs1_addr,
  input  logic            rs1_rden,
  input  r_t              rs2_addr,
  input  logic            rs2_rden,
  input  r_t              rd_addr,
  input  logic            rd_wren,
  input  logic [XLEN-1:0] rd_data,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);

  localparam int AW = $clog2(NUM_REGS);

  function automatic logic in_range(input r_t a);
    return int'(a) < NUM_REGS;
  endfunction

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic            wr_ok;

  assign wr_ok = rd_wren && (rd_addr != X0) && in_range(rd_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[rd_addr[AW-1:0]] <= rd_data;
    end
  end

  r_t              rs_addr   [2];
  logic            rs_rden   [2];
  logic [XLEN-1:0] rs_data_q [2];

  assign rs_addr[0] = rs1_addr;
  assign rs_addr[1] = rs2_addr;
  assign rs_rden[0] = rs1_rden;
  assign rs_rden[1] = rs2_rden;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic [XLEN-1:0] reg_val;
      logic [XLEN-1:0] byp_val;
      logic [XLEN-1:0] rs_data_d;

      assign reg_val = in_range(rs_addr[gi]) ? regs_q[rs_addr[gi][AW-1:0]] : '0;

      reg_bypass #(.W(XLEN)) u_bypass (
        .rs_addr_i (rs_addr[gi]),
        .rd_addr_i (rd_addr),
        .rd_wren_i (rd_wren),
        .rd_data_i (rd_data),
        .reg_val_i (reg_val),
        .value_o   (byp_val)
      );

      // A disabled read yields 0 rather than holding; only stall holds.
      assign rs_data_d = (rs_rden[gi] && (rs_addr[gi] != X0) && in_range(rs_addr[gi]))
                         ? byp_val : '0;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rs_data_q[gi] <= '0;
        else if (!stall) rs_data_q[gi] <= rs_data_d;
      end
    end
  endgenerate

  assign rs1_data = rs_data_q[0];
  assign rs2_data = rs_data_q[1];

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: stimulus queues expected read data, a monitor
// compares it one cycle later. Define REG_WB_BYPASS_EN to match a forwarding build.
module tb_reg_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        rs1_rden, rs2_rden, rd_wren;
  logic [31:0] rd_data;
  logic [31:0] rs1_data, rs2_data;

  reg_bank dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (stall),
    .rs1_addr (rs1_addr),
    .rs1_rden (rs1_rden),
    .rs2_addr (rs2_addr),
    .rs2_rden (rs2_rden),
    .rd_addr  (rd_addr),
    .rd_wren  (rd_wren),
    .rd_data  (rd_data),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          port;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc        = 0;
  int   compared   = 0;
  int   mismatched = 0;

  // Monitor: after each rising edge, compare every expectation due this cycle.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (q.size() > 0 && q[0].due <= cyc) begin
        exp_t e;
        logic [31:0] act;
        e = q.pop_front();
        act = e.port ? rs2_data : rs1_data;
        compared++;
        if (e.due < cyc) begin
          mismatched++;
          $display("FAIL %s: expectation for cycle %0d missed at cycle %0d", e.name, e.due, cyc);
        end else if (act !== e.val) begin
          mismatched++;
          $display("FAIL %s: rs%0d_data got 0x%08h expected 0x%08h", e.name, e.port + 1, act, e.val);
        end else begin
          $display("ok   %s: rs%0d_data = 0x%08h", e.name, e.port + 1, act);
        end
      end
    end
  end

  task automatic step(input bit st, input bit e1, input logic [4:0] a1,
                      input bit e2, input logic [4:0] a2,
                      input bit we, input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clk);
    stall = st; rs1_rden = e1; rs1_addr = a1; rs2_rden = e2; rs2_addr = a2;
    rd_wren = we; rd_addr = wa; rd_data = wd;
  endtask

  task automatic expect_rd(input bit port, input logic [31:0] val, input string name);
    exp_t e;
    e.due = cyc + 1; e.port = port; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 0; rs1_rden = 0; rs2_rden = 0; rd_wren = 0;
    rs1_addr = 0; rs2_addr = 0; rd_addr = 0; rd_data = 0;

    // Reset state: outputs 0 while reset is held, read requests ignored
    step(0, 1, 5'd3, 1, 5'd4, 0, 0, 0);
    expect_rd(0, 32'h0, "reset_state_rs1"); expect_rd(1, 32'h0, "reset_state_rs2");
    @(negedge clk); rst_n = 1'b1;

    // Populate some registers, then read them back
    step(0, 0, 0, 0, 0, 1, 5'd1,  32'h1111_0001);
    step(0, 0, 0, 0, 0, 1, 5'd31, 32'hFFFF_001F);
    step(0, 0, 0, 0, 0, 1, 5'd5,  32'h0000_5555);
    step(0, 1, 5'd1, 1, 5'd31, 0, 0, 0);
    expect_rd(0, 32'h1111_0001, "pre_reset_x1"); expect_rd(1, 32'hFFFF_001F, "pre_reset_x31");

    // Mid-run reset, including a write that must be dropped
    step(0, 1, 5'd5, 1, 5'd1, 1, 5'd2, 32'h2222_2222);
    rst_n = 1'b0;
    expect_rd(0, 32'h0, "in_reset_rs1_a"); expect_rd(1, 32'h0, "in_reset_rs2_a");
    step(0, 1, 5'd5, 1, 5'd1, 0, 0, 0);
    expect_rd(0, 32'h0, "in_reset_rs1_b"); expect_rd(1, 32'h0, "in_reset_rs2_b");
    @(negedge clk); rst_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      step(0, 1, 5'(i), 1, 5'(32 - i), 0, 0, 0);
      expect_rd(0, 32'h0, $sformatf("post_reset_rs1_x%0d", i));
      expect_rd(1, 32'h0, $sformatf("post_reset_rs2_x%0d", 32 - i));
    end

    // Write then read next cycle
    step(0, 0, 0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF);
    step(0, 1, 5'd5, 0, 0, 0, 0, 0);
    expect_rd(0, 32'hDEAD_BEEF, "write_read_x5"); expect_rd(1, 32'h0, "rden0_rs2");

    // x0 is hardwired
    step(0, 0, 0, 0, 0, 1, 5'd0, 32'h0000_1234);
    step(0, 1, 5'd0, 1, 5'd0, 0, 0, 0);
    expect_rd(0, 32'h0, "x0_rs1"); expect_rd(1, 32'h0, "x0_rs2");

    // Same-edge write and read of x7
    step(0, 0, 0, 0, 0, 1, 5'd7, 32'h0000_0011);
    step(0, 0, 0, 0, 0, 1, 5'd6, 32'h0000_0066);
    step(0, 0, 0, 1, 5'd7, 1, 5'd7, 32'hA5A5_A5A5);
`ifdef REG_WB_BYPASS_EN
    expect_rd(1, 32'hA5A5_A5A5, "same_edge_x7_bypass");
`else
    expect_rd(1, 32'h0000_0011, "same_edge_x7_old");
`endif
    step(0, 1, 5'd7, 1, 5'd6, 0, 0, 0);
    expect_rd(0, 32'hA5A5_A5A5, "x7_after_write"); expect_rd(1, 32'h0000_0066, "x6_value");

    // Stall holds output; writes still land during stall
    step(0, 1, 5'd5, 0, 0, 0, 0, 0);
    expect_rd(0, 32'hDEAD_BEEF, "pre_stall_x5");
    step(1, 1, 5'd6, 0, 0, 1, 5'd5, 32'h0);
    expect_rd(0, 32'hDEAD_BEEF, "stall_hold_1");
    step(1, 1, 5'd6, 0, 0, 0, 0, 0);
    expect_rd(0, 32'hDEAD_BEEF, "stall_hold_2");
    step(1, 1, 5'd6, 0, 0, 0, 0, 0);
    expect_rd(0, 32'hDEAD_BEEF, "stall_hold_3");
    step(0, 1, 5'd6, 0, 0, 0, 0, 0);
    expect_rd(0, 32'h0000_0066, "after_stall_x6");
    step(0, 1, 5'd5, 0, 0, 0, 0, 0);
    expect_rd(0, 32'h0, "x5_written_during_stall");

    // Disabled read yields 0 even when the previous output was nonzero
    step(0, 0, 0, 0, 0, 1, 5'd5, 32'hCAFE_F00D);
    step(0, 1, 5'd5, 0, 0, 0, 0, 0);
    expect_rd(0, 32'hCAFE_F00D, "x5_reload");
    step(0, 0, 5'd5, 1, 5'd5, 0, 0, 0);
    expect_rd(0, 32'h0, "rden0_rs1"); expect_rd(1, 32'hCAFE_F00D, "rden1_rs2_x5");

    // Both ports on the same address
    step(0, 1, 5'd31, 1, 5'd31, 1, 5'd31, 32'h3131_3131);
    step(0, 1, 5'd31, 1, 5'd31, 0, 0, 0);
    expect_rd(0, 32'h3131_3131, "same_addr_rs1"); expect_rd(1, 32'h3131_3131, "same_addr_rs2");

    step(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
